// File: rtl/mem_access_monitor_pkg.sv
// Shared types for the data-memory access monitor: error codes, trace entry layout
// and the default three-window memory map (region 0 = ROM, 1 = RAM, 2 = UART).
package mon_pkg;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_UNMAPPED  = 3'd1,
        ERR_WRITE_RO  = 3'd2,
        ERR_BOTH_STRB = 3'd3,
        ERR_NO_STRB   = 3'd4
    } err_code_t;

    localparam int MON_ADDR_W   = 32;
    localparam int MON_REGION_W = 3;

    typedef struct packed {
        logic [MON_ADDR_W-1:0]   pc;
        logic [MON_ADDR_W-1:0]   addr;
        logic [MON_REGION_W-1:0] region;
        logic                    is_store;
        err_code_t               err_code;
    } trace_entry_t;

    // Region r occupies bits [r*32 +: 32], so region 0 is the rightmost field.
    localparam int                  DEF_NUM_REGIONS = 3;
    localparam logic [3*32-1:0]     DEF_REGION_BASE = {32'h0100_0000, 32'h0010_0000, 32'h0000_0000};
    localparam logic [3*32-1:0]     DEF_REGION_LEN  = {32'h0000_0010, 32'h0001_0000, 32'h0001_0000};
    localparam logic [2:0]          DEF_REGION_RO   = 3'b001;

endpackage

// File: rtl/mem_access_monitor_trace_fifo.sv
// Trace FIFO for the access monitor: extra-MSB pointers, drop-on-full with a sticky
// overflow flag, and a simultaneous push+pop accepted even when full.
module mon_trace_fifo #(
    parameter int ENTRY_W = 8,
    parameter int DEPTH   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_data_i,
    input  logic               pop_ready_i,
    output logic               valid_o,
    output logic [ENTRY_W-1:0] data_o,
    output logic               ovf_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               empty;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign pop     = !empty && pop_ready_i;
    // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
    assign push_ok = push_i && (!full || pop);

    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem[rd_ptr[PTR_W-2:0]];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-2:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_i && !push_ok) begin
                ovf_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_monitor.sv
// Data-memory access monitor: region decode, per-region saturating load/store counters,
// sticky first-error capture. The trace FIFO is built only when MEM_MON_TRACE_EN is defined.
module mem_access_monitor
    import mon_pkg::*;
#(
    parameter int                            NUM_REGIONS = DEF_NUM_REGIONS,
    parameter int                            ADDR_W      = MON_ADDR_W,
    parameter int                            CNT_W       = 16,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LEN  = DEF_REGION_LEN,
    parameter logic [NUM_REGIONS-1:0]        REGION_RO   = DEF_REGION_RO,
    parameter int                            TRACE_DEPTH = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              req_valid_i,
    input  logic [ADDR_W-1:0]                 req_addr_i,
    input  logic [ADDR_W-1:0]                 req_pc_i,
    input  logic [3:0]                        req_rstrb_i,
    input  logic [3:0]                        req_wstrb_i,
    input  logic [$clog2(NUM_REGIONS):0]      cnt_sel_i,
    output logic [CNT_W-1:0]                  cnt_o,
    output logic                              err_o,
    output logic [2:0]                        err_code_o,
    output logic [ADDR_W-1:0]                 err_addr_o,
    output logic [ADDR_W-1:0]                 err_pc_o,
    output logic                              trace_valid_o,
    input  logic                              trace_ready_i,
    output logic [$bits(trace_entry_t)-1:0]   trace_data_o,
    output logic                              trace_ovf_o
);

    localparam int REG_IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic {ST_ARMED, ST_TRIPPED} mon_state_t;

    logic [NUM_REGIONS-1:0] hit;
    logic                   hit_any;
    logic [REG_IDX_W-1:0]   hit_idx;
    logic                   rd_any;
    logic                   wr_any;
    err_code_t              code;
    mon_state_t             state;
    logic [CNT_W-1:0]       ld_cnt [NUM_REGIONS];
    logic [CNT_W-1:0]       st_cnt [NUM_REGIONS];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Window end is formed one bit wider so a window ending at 2^ADDR_W does not wrap.
    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_dec
        logic [ADDR_W:0] base_x;
        logic [ADDR_W:0] end_x;
        assign base_x = {1'b0, REGION_BASE[r*ADDR_W +: ADDR_W]};
        assign end_x  = base_x + {1'b0, REGION_LEN[r*ADDR_W +: ADDR_W]};
        assign hit[r] = ({1'b0, req_addr_i} >= base_x) && ({1'b0, req_addr_i} < end_x);
    end

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (hit[r]) begin
                hit_any = 1'b1;
                hit_idx = REG_IDX_W'(r);
            end
        end
    end

    assign rd_any = |req_rstrb_i;
    assign wr_any = |req_wstrb_i;

    always_comb begin
        if (rd_any && wr_any) begin
            code = ERR_BOTH_STRB;
        end else if (!rd_any && !wr_any) begin
            code = ERR_NO_STRB;
        end else if (!hit_any) begin
            code = ERR_UNMAPPED;
        end else if (wr_any && REGION_RO[hit_idx]) begin
            code = ERR_WRITE_RO;
        end else begin
            code = ERR_NONE;
        end
    end

    // ---- counter stage: legal accesses land in their region one cycle later ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                ld_cnt[r] <= '0;
                st_cnt[r] <= '0;
            end
        end else if (clear_i) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                ld_cnt[r] <= '0;
                st_cnt[r] <= '0;
            end
        end else if (req_valid_i && (code == ERR_NONE)) begin
            for (int r = 0; r < NUM_REGIONS; r++) begin
                if (hit_idx == REG_IDX_W'(r)) begin
                    if (wr_any) begin
                        st_cnt[r] <= sat_inc(st_cnt[r]);
                    end else begin
                        ld_cnt[r] <= sat_inc(ld_cnt[r]);
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (int'(cnt_sel_i >> 1) == r) begin
                cnt_o = cnt_sel_i[0] ? st_cnt[r] : ld_cnt[r];
            end
        end
    end

    // ---- error capture stage: first error only, released solely by clear ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_ARMED;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_addr_o <= '0;
            err_pc_o   <= '0;
        end else if (clear_i) begin
            state      <= ST_ARMED;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            err_addr_o <= '0;
            err_pc_o   <= '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (req_valid_i && (code != ERR_NONE)) begin
                        state      <= ST_TRIPPED;
                        err_o      <= 1'b1;
                        err_code_o <= code;
                        err_addr_o <= req_addr_i;
                        err_pc_o   <= req_pc_i;
                    end
                end
                default: begin
                    state <= ST_TRIPPED;
                end
            endcase
        end
    end

`ifdef MEM_MON_TRACE_EN
    trace_entry_t entry;

    always_comb begin
        entry          = '0;
        entry.pc       = MON_ADDR_W'(req_pc_i);
        entry.addr     = MON_ADDR_W'(req_addr_i);
        entry.region   = hit_any ? MON_REGION_W'(hit_idx) : '0;
        entry.is_store = wr_any;
        entry.err_code = code;
    end

    mon_trace_fifo #(
        .ENTRY_W ($bits(trace_entry_t)),
        .DEPTH   (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (req_valid_i && !clear_i),
        .push_data_i (entry),
        .pop_ready_i (trace_ready_i),
        .valid_o     (trace_valid_o),
        .data_o      (trace_data_o),
        .ovf_o       (trace_ovf_o)
    );
`else
    logic unused_trace_ready;
    assign unused_trace_ready = trace_ready_i;
    assign trace_valid_o      = 1'b0;
    assign trace_data_o       = '0;
    assign trace_ovf_o        = 1'b0;
`endif

endmodule
